// File: rtl/ascon_bdi_driver_pkg.sv
// Shared types and helpers for the Ascon input-side sequencer and its output-side twin.
package ascon_bdi_driver_pkg;

    typedef enum logic [2:0] {
        M_NONE = 3'd0,
        M_ENC  = 3'd1,
        M_DEC  = 3'd2,
        M_HASH = 3'd3,
        M_XOF  = 3'd4,
        M_CXOF = 3'd5
    } e_mode;

    typedef enum logic [3:0] {
        D_NULL  = 4'd0,
        D_NONCE = 4'd1,
        D_AD    = 4'd2,
        D_MSG   = 4'd3,
        D_TAG   = 4'd4
    } e_data_type;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MODE      = 3'd1,
        S_KEY       = 3'd2,
        S_NPUB      = 3'd3,
        S_AD        = 3'd4,
        S_MSG       = 3'd5,
        S_TAG       = 3'd6,
        S_WAIT_DONE = 3'd7
    } e_state;

    // Low-order byte-lane mask for a word carrying min(rem, bpw) valid bytes.
    function automatic logic [7:0] len_mask(input logic [3:0] rem, input logic [3:0] bpw);
        logic [8:0] m;
        if (rem >= bpw) m = (9'd1 << bpw) - 9'd1;
        else            m = (9'd1 << rem) - 9'd1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/ascon_bdi_driver.sv
// Sequences one host command into ascon_core mode/key/bdi transfers with derived framing.
module ascon_bdi_driver
    import ascon_bdi_driver_pkg::*;
#(
    parameter int CCW  = 32,
    parameter int LENW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  e_mode               cmd_mode,
    input  logic                cmd_key_new,
    input  logic [LENW-1:0]     cmd_ad_len,
    input  logic [LENW-1:0]     cmd_msg_len,
    output logic                cmd_err,
    input  logic [CCW-1:0]      h_data,
    input  logic                h_valid,
    output logic                h_ready,
    output e_mode               mode,
    output logic [CCW-1:0]      key,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [CCW-1:0]      bdi,
    output logic [CCW/8-1:0]    bdi_valid,
    output e_data_type          bdi_type,
    output logic                bdi_eot,
    output logic                bdi_eoi,
    input  logic                bdi_ready,
    input  logic                done,
    output logic                busy,
    output e_state              dbg_state
);

    localparam int BPW = CCW / 8;
    localparam int WPB = 128 / CCW;
    localparam logic [1:0]      WLAST = 2'(WPB - 1);
    localparam logic [LENW-1:0] BPW_L = LENW'(BPW);

    e_state          state_q;
    e_mode           mode_q;
    logic            key_new_q;
    logic [LENW-1:0] ad_rem_q;
    logic [LENW-1:0] msg_rem_q;
    logic [1:0]      wcnt_q;
    logic            cmd_err_q;

    logic            is_aead, is_dec, wlast, seg_last, xfer;
    logic [LENW-1:0] seg_rem, seg_take;
    logic [BPW-1:0]  seg_mask;
    e_state          after_payload;

    assign is_aead       = (mode_q == M_ENC) || (mode_q == M_DEC);
    assign is_dec        = (mode_q == M_DEC);
    assign wlast         = (wcnt_q == WLAST);
    assign after_payload = is_dec ? S_TAG : S_WAIT_DONE;
    assign seg_rem       = (state_q == S_AD) ? ad_rem_q : msg_rem_q;
    assign seg_last      = (seg_rem <= BPW_L);
    assign seg_take      = seg_last ? seg_rem : BPW_L;
    assign seg_mask      = BPW'(len_mask(4'(seg_take), 4'(BPW)));

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign cmd_err   = cmd_err_q;
    assign dbg_state = state_q;

    // Valid/h_ready depend only on state, h_valid and the core ready; never ready -> valid.
    always_comb begin
        mode      = M_NONE;
        key       = '0;
        key_valid = 1'b0;
        bdi       = '0;
        bdi_valid = '0;
        bdi_type  = D_NULL;
        bdi_eot   = 1'b0;
        bdi_eoi   = 1'b0;
        h_ready   = 1'b0;
        xfer      = 1'b0;
        case (state_q)
            S_MODE: begin
                mode      = mode_q;
                key_valid = is_aead && key_new_q;
                bdi_eoi   = !is_aead && (mode_q != M_CXOF) && (msg_rem_q == '0);
            end
            S_KEY: begin
                key       = h_data;
                key_valid = h_valid;
                h_ready   = key_ready;
                xfer      = h_valid && key_ready;
            end
            S_NPUB: begin
                bdi       = h_data;
                bdi_valid = {BPW{h_valid}};
                bdi_type  = D_NONCE;
                bdi_eoi   = wlast && (ad_rem_q == '0) && (msg_rem_q == '0);
                h_ready   = bdi_ready;
                xfer      = h_valid && bdi_ready;
            end
            S_AD: begin
                bdi       = h_data;
                bdi_valid = h_valid ? seg_mask : '0;
                bdi_type  = D_AD;
                bdi_eot   = seg_last;
                bdi_eoi   = seg_last && (msg_rem_q == '0);
                h_ready   = bdi_ready;
                xfer      = h_valid && bdi_ready;
            end
            S_MSG: begin
                bdi       = h_data;
                bdi_valid = h_valid ? seg_mask : '0;
                bdi_type  = D_MSG;
                bdi_eot   = seg_last;
                bdi_eoi   = seg_last;
                h_ready   = bdi_ready;
                xfer      = h_valid && bdi_ready;
            end
            S_TAG: begin
                bdi       = h_data;
                bdi_valid = {BPW{h_valid}};
                bdi_type  = D_TAG;
                h_ready   = bdi_ready;
                xfer      = h_valid && bdi_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= M_NONE;
            key_new_q <= 1'b0;
            ad_rem_q  <= '0;
            msg_rem_q <= '0;
            wcnt_q    <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_mode == M_CXOF && cmd_ad_len == '0) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            mode_q    <= cmd_mode;
                            key_new_q <= cmd_key_new && (cmd_mode == M_ENC || cmd_mode == M_DEC);
                            ad_rem_q  <= (cmd_mode == M_HASH || cmd_mode == M_XOF) ? '0 : cmd_ad_len;
                            msg_rem_q <= cmd_msg_len;
                            wcnt_q    <= '0;
                            state_q   <= S_MODE;
                        end
                    end
                end
                S_MODE: begin
                    if (is_aead)                 state_q <= key_new_q ? S_KEY : S_NPUB;
                    else if (mode_q == M_CXOF)   state_q <= S_AD;
                    else                         state_q <= (msg_rem_q == '0) ? S_WAIT_DONE : S_MSG;
                end
                S_KEY: begin
                    if (xfer) begin
                        wcnt_q <= wlast ? 2'd0 : wcnt_q + 2'd1;
                        if (wlast) state_q <= S_NPUB;
                    end
                end
                S_NPUB: begin
                    if (xfer) begin
                        wcnt_q <= wlast ? 2'd0 : wcnt_q + 2'd1;
                        if (wlast) begin
                            if (ad_rem_q != '0)       state_q <= S_AD;
                            else if (msg_rem_q != '0) state_q <= S_MSG;
                            else                      state_q <= after_payload;
                        end
                    end
                end
                S_AD: begin
                    if (xfer) begin
                        ad_rem_q <= ad_rem_q - seg_take;
                        if (seg_last) state_q <= (msg_rem_q != '0) ? S_MSG : after_payload;
                    end
                end
                S_MSG: begin
                    if (xfer) begin
                        msg_rem_q <= msg_rem_q - seg_take;
                        if (seg_last) state_q <= after_payload;
                    end
                end
                S_TAG: begin
                    if (xfer) begin
                        wcnt_q <= wlast ? 2'd0 : wcnt_q + 2'd1;
                        if (wlast) state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (done) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_bdi_driver.sv
// Directed bench for ascon_bdi_driver at CCW = 32: framing, stalls, reset and command rejection.
module tb_ascon_bdi_driver;
    import ascon_bdi_driver_pkg::*;

    localparam int CCW  = 32;
    localparam int LENW = 32;
    localparam int BPW  = CCW / 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    e_mode              cmd_mode;
    logic               cmd_key_new;
    logic [LENW-1:0]    cmd_ad_len;
    logic [LENW-1:0]    cmd_msg_len;
    logic               cmd_err;
    logic [CCW-1:0]     h_data;
    logic               h_valid;
    logic               h_ready;
    e_mode              mode;
    logic [CCW-1:0]     key;
    logic               key_valid;
    logic               key_ready;
    logic [CCW-1:0]     bdi;
    logic [BPW-1:0]     bdi_valid;
    e_data_type         bdi_type;
    logic               bdi_eot;
    logic               bdi_eoi;
    logic               bdi_ready;
    logic               done;
    logic               busy;
    e_state             dbg_state;

    int total = 0;
    int bad   = 0;

    ascon_bdi_driver #(.CCW(CCW), .LENW(LENW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_key_new(cmd_key_new), .cmd_ad_len(cmd_ad_len), .cmd_msg_len(cmd_msg_len),
        .cmd_err(cmd_err),
        .h_data(h_data), .h_valid(h_valid), .h_ready(h_ready),
        .mode(mode), .key(key), .key_valid(key_valid), .key_ready(key_ready),
        .bdi(bdi), .bdi_valid(bdi_valid), .bdi_type(bdi_type), .bdi_eot(bdi_eot),
        .bdi_eoi(bdi_eoi), .bdi_ready(bdi_ready),
        .done(done), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input e_mode m, input logic kn, input int ad, input int msg);
        cmd_mode    = m;
        cmd_key_new = kn;
        cmd_ad_len  = LENW'(ad);
        cmd_msg_len = LENW'(msg);
        cmd_valid   = 1'b1;
        #1;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic key_word(input string tag);
        h_data    = $urandom;
        h_valid   = 1'b1;
        key_ready = 1'b1;
        #1;
        check({tag, "_data"}, key, h_data);
        check({tag, "_ctl"}, {key_valid, h_ready, bdi_type}, {1'b1, 1'b1, D_NULL});
        tick();
        key_ready = 1'b0;
    endtask

    // One accepted bdi word: mask, type, eot, eoi and h_ready checked together.
    task automatic data_word(input string tag, input e_data_type t, input logic [BPW-1:0] m,
                             input logic eot, input logic eoi);
        h_data    = $urandom;
        h_valid   = 1'b1;
        bdi_ready = 1'b1;
        #1;
        check({tag, "_data"}, bdi, h_data);
        check({tag, "_ctl"}, {bdi_valid, bdi_type, bdi_eot, bdi_eoi, h_ready}, {m, t, eot, eoi, 1'b1});
        tick();
    endtask

    task automatic finish_done(input string tag);
        h_valid = 1'b1;
        #1;
        check({tag, "_wait"}, {busy, cmd_ready, bdi_valid, key_valid, h_ready, dbg_state},
              {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, S_WAIT_DONE});
        done = 1'b1;
        tick();
        done = 1'b0;
        #1;
        check({tag, "_idle"}, {busy, cmd_ready}, {1'b0, 1'b1});
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = M_NONE; cmd_key_new = 1'b0;
        cmd_ad_len = '0; cmd_msg_len = '0; h_data = '0; h_valid = 1'b0;
        key_ready = 1'b0; bdi_ready = 1'b0; done = 1'b0;

        #12;
        check("rst_outputs", {cmd_ready, busy, key_valid, bdi_valid, bdi_type, mode, h_ready, cmd_err},
              {1'b0, 1'b0, 1'b0, 4'h0, D_NULL, M_NONE, 1'b0, 1'b0});
        tick();
        rst = 1'b0;
        #1;
        check("rst_release", {cmd_ready, busy}, {1'b1, 1'b0});

        // M_ENC, new key, ad = 5, msg = 0
        issue(M_ENC, 1'b1, 5, 0);
        h_valid = 1'b0;
        #1;
        check("enc_mode", {mode, key_valid, bdi_eoi, busy, cmd_ready}, {M_ENC, 1'b1, 1'b0, 1'b1, 1'b0});
        tick();
        for (int i = 0; i < 4; i++) key_word("enc_key");
        for (int i = 0; i < 4; i++) data_word("enc_npub", D_NONCE, 4'hF, 1'b0, 1'b0);
        data_word("enc_ad0", D_AD, 4'hF, 1'b0, 1'b0);
        data_word("enc_ad1", D_AD, 4'h1, 1'b1, 1'b1);
        finish_done("enc");

        // M_HASH, empty message; stray command while busy must be ignored
        issue(M_HASH, 1'b0, 7, 0);
        h_valid = 1'b0;
        #1;
        check("hash_mode", {mode, key_valid, bdi_eoi, bdi_valid}, {M_HASH, 1'b0, 1'b1, 4'h0});
        tick();
        cmd_valid = 1'b1;
        cmd_mode  = M_ENC;
        h_valid   = 1'b1;
        bdi_ready = 1'b1;
        #1;
        check("hash_busy_cmd", {cmd_ready, bdi_valid, dbg_state}, {1'b0, 4'h0, S_WAIT_DONE});
        tick();
        cmd_valid = 1'b0;
        finish_done("hash");

        // M_DEC, old key, ad = 0, msg = 8, with core and host stalls mid-message
        issue(M_DEC, 1'b0, 0, 8);
        h_valid = 1'b0;
        #1;
        check("dec_mode", {mode, key_valid}, {M_DEC, 1'b0});
        tick();
        for (int i = 0; i < 4; i++) data_word("dec_npub", D_NONCE, 4'hF, 1'b0, 1'b0);
        data_word("dec_msg0", D_MSG, 4'hF, 1'b0, 1'b0);
        bdi_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            h_data  = $urandom;
            h_valid = 1'b1;
            #1;
            check("dec_core_stall_data", bdi, h_data);
            check("dec_core_stall_ctl", {h_ready, bdi_valid, bdi_type, bdi_eot, bdi_eoi},
                  {1'b0, 4'hF, D_MSG, 1'b1, 1'b1});
            tick();
        end
        bdi_ready = 1'b1;
        h_valid   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("dec_host_stall_ctl", {h_ready, bdi_valid, bdi_type, bdi_eot, bdi_eoi},
                  {1'b1, 4'h0, D_MSG, 1'b1, 1'b1});
            tick();
        end
        data_word("dec_msg1", D_MSG, 4'hF, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) data_word("dec_tag", D_TAG, 4'hF, 1'b0, 1'b0);
        finish_done("dec");

        // M_CXOF with 3 customization bytes, empty message
        issue(M_CXOF, 1'b0, 3, 0);
        h_valid = 1'b0;
        #1;
        check("cxof_mode", {mode, bdi_eoi, key_valid}, {M_CXOF, 1'b0, 1'b0});
        tick();
        data_word("cxof_ad", D_AD, 4'h7, 1'b1, 1'b1);
        finish_done("cxof");

        // Reset in the middle of a 3-word AD segment
        issue(M_ENC, 1'b0, 9, 0);
        #1;
        check("rst_case_mode", {mode, key_valid}, {M_ENC, 1'b0});
        tick();
        for (int i = 0; i < 4; i++) data_word("rst_npub", D_NONCE, 4'hF, 1'b0, 1'b0);
        data_word("rst_ad0", D_AD, 4'hF, 1'b0, 1'b0);
        h_valid = 1'b1;
        rst     = 1'b1;
        #1;
        check("rst_mid_outputs", {cmd_ready, busy, bdi_valid, bdi_type, bdi_eot, bdi_eoi, h_ready, mode},
              {1'b0, 1'b0, 4'h0, D_NULL, 1'b0, 1'b0, 1'b0, M_NONE});
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_release", {cmd_ready, busy, dbg_state}, {1'b1, 1'b0, S_IDLE});

        // M_CXOF with empty customization is rejected
        h_valid = 1'b0;
        issue(M_CXOF, 1'b0, 0, 4);
        #1;
        check("cxof0_err", {cmd_err, busy, cmd_ready, bdi_valid, mode}, {1'b1, 1'b0, 1'b1, 4'h0, M_NONE});
        tick();
        check("cxof0_err_pulse", {cmd_err, busy}, {1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
